// File: rtl/otter_intr_ctrl.sv
// N-channel MMIO interrupt controller: sync, edge/level, mask, fixed priority, claim/complete.
// Latency: IRQ edge -> PEND in SYNC_STAGES+1 cycles -> INTR +1; MMIO reads return 1 cycle after address.
// Backpressure: none; a single claim is outstanding and INTR stays low until it is completed.
module otter_intr_ctrl #(
    parameter int          N_CH        = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [N_CH-1:0] IRQ_IN,
    input  logic [31:0]     IOBUS_ADDR,
    input  logic [31:0]     IOBUS_OUT,
    input  logic            IOBUS_WR,
    input  logic            INT_TAKEN,
    output logic [31:0]     RD_DATA,
    output logic            RD_HIT,
    output logic            INTR
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t                           state_q, state_d;
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  s, s_prev, rise, pend, enable, mode, req, w1c, claim_clr;
    logic [4:0]                       claim_id, claim_id_d, sel;
    logic                             take, addr_hit, wr_hit, complete;
    logic [1:0]                       reg_sel;
    logic [31:0]                      rd_d, claim_p1;

    assign addr_hit = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign wr_hit   = IOBUS_WR && addr_hit && (IOBUS_ADDR[1:0] == 2'b00);
    assign reg_sel  = IOBUS_ADDR[3:2];
    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~s_prev;
    assign req      = pend & enable;
    assign claim_p1 = 32'(claim_id) + 32'd1;
    assign w1c      = (wr_hit && reg_sel == 2'd0) ? IOBUS_OUT[N_CH-1:0] : '0;
    assign complete = wr_hit && (reg_sel == 2'd3) && (IOBUS_OUT == claim_p1);

    // Lowest index wins: scan downward so the last hit is the smallest channel.
    always_comb begin
        sel = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) sel = 5'(i);
        end
    end

    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < N_CH; i++) begin
            claim_clr[i] = take && (sel == 5'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        claim_id_d = claim_id;
        take       = 1'b0;
        INTR       = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) state_d = REQ;
            end
            REQ: begin
                INTR = 1'b1;
                if (INT_TAKEN) begin
                    if (|req) begin
                        take       = 1'b1;
                        claim_id_d = sel;
                        state_d    = SERVICE;
                    end else begin
                        claim_id_d = '0;
                        state_d    = IDLE;
                    end
                end else if (!(|req)) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (complete) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_d = '0;
        if (addr_hit) begin
            case (reg_sel)
                2'd0:    rd_d = 32'(pend);
                2'd1:    rd_d = 32'(enable);
                2'd2:    rd_d = 32'(mode);
                default: rd_d = (state_q == SERVICE) ? claim_p1 : 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q   <= '0;
            s_prev   <= '0;
            pend     <= '0;
            enable   <= '0;
            mode     <= '0;
            state_q  <= IDLE;
            claim_id <= '0;
            RD_DATA  <= '0;
            RD_HIT   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], IRQ_IN};
            s_prev <= s;
            // Edge channels: a fresh rise beats any same-cycle clear. Level channels track s.
            pend   <= (mode & ((pend & ~w1c & ~claim_clr) | rise)) | (~mode & s);
            if (wr_hit && reg_sel == 2'd1) enable <= IOBUS_OUT[N_CH-1:0];
            if (wr_hit && reg_sel == 2'd2) mode   <= IOBUS_OUT[N_CH-1:0];
            state_q  <= state_d;
            claim_id <= claim_id_d;
            RD_DATA  <= rd_d;
            RD_HIT   <= addr_hit;
        end
    end
endmodule
